// File: rtl/depatchifier_if.sv
// Handshake and data bundle between the patch producer, the depatchifier and
// the downstream consumer of the reassembled 2D patch.
interface depatchifier_if #(
    parameter int PIXEL_WIDTH       = 24,
    parameter int PATCH_SIZE        = 4,
    parameter int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE
);
    logic                                                 in_valid;
    logic [PATCH_VECTOR_SIZE-1:0][PIXEL_WIDTH-1:0]        in_vector;
    logic                                                 in_taken;
    logic                                                 out_taken;
    logic [PATCH_SIZE-1:0][PATCH_SIZE-1:0][PIXEL_WIDTH-1:0] patch_out;
    logic                                                 out_valid;

    // Producer and consumer side: drives the vector and the consume strobe.
    modport master (
        output in_valid, in_vector, out_taken,
        input  in_taken, patch_out, out_valid
    );

    // Depatchifier side.
    modport slave (
        input  in_valid, in_vector, out_taken,
        output in_taken, patch_out, out_valid
    );
endinterface

// File: rtl/depatchifier.sv
// Reassembles a flattened row-major patch vector into a PATCH_SIZE x PATCH_SIZE
// patch, one pixel per cycle, and holds it under a valid/taken handshake.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   IDLE       | waiting for in_valid; captures in_vector on that edge
//   PROCESSING | copies one pixel per edge into patch_out, index 0..N-1
//   DONE       | out_valid high, patch_out stable until out_taken
//   2'b11      | unreachable; recovers to IDLE on the next edge
module depatchifier #(
    parameter int CHANNEL_SIZE      = 8,
    parameter int NUM_CHANNELS      = 3,
    parameter int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS,
    parameter int PATCH_SIZE        = 4,
    parameter int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE
) (
    input  logic         clk,
    input  logic         reset,
    depatchifier_if.slave bus,
    output logic [1:0]   state
);
    localparam int IW = (PATCH_VECTOR_SIZE > 1) ? $clog2(PATCH_VECTOR_SIZE) : 1;
    localparam int RW = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        PROCESSING = 2'b01,
        DONE       = 2'b10,
        ILLEGAL    = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic [PATCH_VECTOR_SIZE-1:0][PIXEL_WIDTH-1:0]          vec_q;
    logic [PATCH_SIZE-1:0][PATCH_SIZE-1:0][PIXEL_WIDTH-1:0] patch_q;
    logic [IW-1:0] idx_q;
    logic          in_taken_q;
    logic          out_valid_q;
    logic [RW-1:0] row, col;
    logic          last;

    // Row/column of the pixel being written; bit slices when PATCH_SIZE is 2^n.
    assign row  = RW'(idx_q / IW'(PATCH_SIZE));
    assign col  = RW'(idx_q % IW'(PATCH_SIZE));
    assign last = (idx_q == IW'(PATCH_VECTOR_SIZE - 1));

    assign bus.in_taken  = in_taken_q;
    assign bus.out_valid = out_valid_q;
    assign bus.patch_out = patch_q;
    assign state         = state_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state selection; out_taken only matters in DONE, in_valid only in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (bus.in_valid)  state_d = PROCESSING;
            PROCESSING: if (last)          state_d = DONE;
            DONE:       if (bus.out_taken) state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // Capture, pixel-by-pixel reassembly and handshake flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_q       <= '0;
            patch_q     <= '0;
            idx_q       <= '0;
            in_taken_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            in_taken_q  <= (state_q == IDLE) && bus.in_valid;
            out_valid_q <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        vec_q   <= bus.in_vector;
                        patch_q <= '0;
                        idx_q   <= '0;
                    end
                end
                PROCESSING: begin
                    patch_q[row][col] <= vec_q[idx_q];
                    idx_q             <= last ? '0 : idx_q + 1'b1;
                end
                DONE: begin
                    if (bus.out_taken) patch_q <= '0;
                end
                default: begin
                    patch_q <= '0;
                    idx_q   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_depatchifier.sv
// Self-checking bench for depatchifier: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model.
module tb_depatchifier;
    localparam int PW  = 24;
    localparam int PS  = 4;
    localparam int PVS = PS * PS;
    localparam int TW  = PS * PS * PW;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state;
    int         cyc   = 0;

    depatchifier_if #(.PIXEL_WIDTH(PW), .PATCH_SIZE(PS), .PATCH_VECTOR_SIZE(PVS)) bus ();

    depatchifier #(
        .CHANNEL_SIZE(8), .NUM_CHANNELS(3), .PIXEL_WIDTH(PW),
        .PATCH_SIZE(PS), .PATCH_VECTOR_SIZE(PVS)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: a patch is either absent, or captured m_k edges ago.
    // After m_k edges, min(m_k, PVS) pixels are in place; DONE once all are.
    logic [PW-1:0] m_vec [PVS];
    bit            m_busy = 1'b0;
    int            m_k    = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_k    = 0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy = 1'b1;
                m_k    = 0;
                for (int k = 0; k < PVS; k++) m_vec[k] = bus.in_vector[k];
            end
        end else if (m_k >= PVS) begin
            if (bus.out_taken) m_busy = 1'b0;
        end else begin
            m_k++;
        end
    end

    function automatic logic [TW-1:0] model_patch();
        logic [PS-1:0][PS-1:0][PW-1:0] p;
        p = '0;
        if (m_busy)
            for (int k = 0; k < PVS; k++)
                if (k < m_k) p[k / PS][k % PS] = m_vec[k];
        return p;
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("state", TW'(state), TW'(!m_busy ? 2'b00 : (m_k < PVS ? 2'b01 : 2'b10)));
            check("in_taken", TW'(bus.in_taken), TW'(m_busy && m_k == 0));
            check("out_valid", TW'(bus.out_valid), TW'(m_busy && m_k >= PVS));
            check("patch_out", bus.patch_out, model_patch());
        end
    end

    task automatic load_seq(input int base);
        for (int k = 0; k < PVS; k++) bus.in_vector[k] = PW'(base + k);
    endtask

    // Steps negedges until out_valid is seen; edges counts the capture edge as 1.
    task automatic wait_valid(input string name, output int edges);
        bit ok;
        ok = 1'b0;
        edges = 1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            edges++;
            if (bus.out_valid) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL %s_timeout: got no out_valid expected out_valid within 40 cycles", name);
        end
    endtask

    int edges, pulses, taken_cnt, nv;
    int ov_time [2];

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_vector = '0;
        bus.out_taken = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_state", TW'(state), TW'(2'b00));
        check("rst_in_taken", TW'(bus.in_taken), TW'(1'b0));
        check("rst_out_valid", TW'(bus.out_valid), TW'(1'b0));
        check("rst_patch", bus.patch_out, '0);
        reset = 1'b0;
        @(negedge clk);

        // Basic ordering: element k = k+1
        load_seq(1);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("basic_in_taken", TW'(bus.in_taken), TW'(1'b1));
        wait_valid("basic", edges);
        check("basic_latency", TW'(edges), TW'(17));
        check("basic_p00", TW'(bus.patch_out[0][0]), TW'(24'd1));
        check("basic_p12", TW'(bus.patch_out[1][2]), TW'(24'd7));
        check("basic_p33", TW'(bus.patch_out[3][3]), TW'(24'd16));

        // Backpressure: hold DONE for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_state", TW'(state), TW'(2'b10));
            check("bp_p21", TW'(bus.patch_out[2][1]), TW'(24'd10));
        end
        bus.out_taken = 1'b1;
        @(negedge clk);
        bus.out_taken = 1'b0;
        check("release_state", TW'(state), TW'(2'b00));
        check("release_patch", bus.patch_out, '0);
        check("release_out_valid", TW'(bus.out_valid), TW'(1'b0));

        // Input isolation: vector overwritten and in_valid held during PROCESSING
        load_seq(24'h00A000);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("iso_in_taken", TW'(bus.in_taken), TW'(1'b1));
        for (int k = 0; k < PVS; k++) bus.in_vector[k] = 24'hFFFFFF;
        pulses = 0;
        edges  = 1;
        for (int i = 0; i < 40 && !bus.out_valid; i++) begin
            @(negedge clk);
            edges++;
            if (bus.in_taken) pulses++;
        end
        bus.in_valid = 1'b0;
        check("iso_latency", TW'(edges), TW'(17));
        check("iso_extra_taken", TW'(pulses), TW'(0));
        check("iso_p33", TW'(bus.patch_out[3][3]), TW'(24'h00A00F));
        check("iso_p00", TW'(bus.patch_out[0][0]), TW'(24'h00A000));
        bus.out_taken = 1'b1;
        @(negedge clk);
        bus.out_taken = 1'b0;

        // Mid-operation reset after index 7 written
        load_seq(24'h123400);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_p13_written", TW'(bus.patch_out[1][3]), TW'(24'h123407));
        #1 reset = 1'b1;
        #1;
        check("midrst_state", TW'(state), TW'(2'b00));
        check("midrst_out_valid", TW'(bus.out_valid), TW'(1'b0));
        check("midrst_in_taken", TW'(bus.in_taken), TW'(1'b0));
        check("midrst_patch", bus.patch_out, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Fresh vector after reset, also pinning the full pixel width
        for (int k = 0; k < PVS; k++) bus.in_vector[k] = PW'($urandom);
        bus.in_vector[5] = 24'hABCDEF;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid("fresh", edges);
        check("fresh_latency", TW'(edges), TW'(17));
        check("pixw_p11", TW'(bus.patch_out[1][1]), TW'(24'hABCDEF));
        bus.out_taken = 1'b1;
        @(negedge clk);
        bus.out_taken = 1'b0;

        // Back-to-back with in_valid held and out_taken tied high
        load_seq(24'h000100);
        bus.in_valid  = 1'b1;
        bus.out_taken = 1'b1;
        taken_cnt = 0;
        nv = 0;
        for (int i = 0; i < 80 && nv < 2; i++) begin
            @(negedge clk);
            if (bus.in_taken) begin
                taken_cnt++;
                if (taken_cnt == 1) load_seq(24'h000200);
                if (taken_cnt == 2) bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                ov_time[nv] = cyc;
                check("b2b_p33", TW'(bus.patch_out[3][3]), TW'(nv == 0 ? 24'h00010F : 24'h00020F));
                check("b2b_p00", TW'(bus.patch_out[0][0]), TW'(nv == 0 ? 24'h000100 : 24'h000200));
                nv++;
            end
        end
        check("b2b_valid_count", TW'(nv), TW'(2));
        check("b2b_taken_count", TW'(taken_cnt), TW'(2));
        if (nv == 2) check("b2b_period", TW'(ov_time[1] - ov_time[0]), TW'(18));
        bus.in_valid  = 1'b0;
        bus.out_taken = 1'b0;
        repeat (3) @(negedge clk);

        // Random traffic, including input changes while busy
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            bus.in_valid  = ($urandom_range(2) == 0);
            bus.out_taken = ($urandom_range(1) == 0);
            for (int k = 0; k < PVS; k++) bus.in_vector[k] = PW'($urandom);
        end
        bus.in_valid  = 1'b0;
        bus.out_taken = 1'b1;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/depatchifier.md
Name: depatchifier

Overview:
- Inverse of the patch vectorizer. Accepts one flattened patch vector (PATCH_VECTOR_SIZE pixels, row-major) from the vectorizer's DONE-stage output.
- Reassembles the vector into a PATCH_SIZE x PATCH_SIZE 2D patch, one pixel per cycle.
- Presents the 2D patch downstream under a valid/taken handshake.
- Its in_taken output drives the vectorizer's output_taken input.

Parameters:
CHANNEL_SIZE, 8, bits per colour channel
NUM_CHANNELS, 3, channels per pixel (RGB)
PIXEL_WIDTH, CHANNEL_SIZE*NUM_CHANNELS, bits per pixel
PATCH_SIZE, 4, patch edge length in pixels
PATCH_VECTOR_SIZE, PATCH_SIZE*PATCH_SIZE, pixels per patch vector

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_vector holds a complete patch vector
in_vector  input  [PIXEL_WIDTH-1:0] x [PATCH_VECTOR_SIZE]  flattened patch; element k is row k/PATCH_SIZE, column k%PATCH_SIZE
in_taken  output  1  one-cycle pulse: vector captured; producer may clear
out_taken  input  1  downstream has consumed patch_out
patch_out  output  [PIXEL_WIDTH-1:0] x [PATCH_SIZE][PATCH_SIZE]  reassembled patch
out_valid  output  1  patch_out complete and stable
state  output  2  FSM state, for debug/status

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values (asynchronous, take effect immediately): state=IDLE(2'b00), in_taken=0, out_valid=0, patch_out all zero, internal vector register all zero, pixel index=0.
- State encoding: IDLE=2'b00, PROCESSING=2'b01, DONE=2'b10. 2'b11 is illegal; if reached, the next edge goes to IDLE.
- IDLE:
  - On an edge with in_valid=1: copy in_vector into the internal vector register, zero patch_out, set index=0, go to PROCESSING, set in_taken<=1.
  - in_valid=0: hold.
- in_taken:
  - Registered; high for exactly the first PROCESSING cycle, 0 otherwise.
  - The producer samples it at the following edge.
- PROCESSING:
  - Each edge writes patch_out[index/PATCH_SIZE][index%PATCH_SIZE] <= vector[index], then index <= index+1.
  - On the edge writing index PATCH_VECTOR_SIZE-1: go to DONE, reset index to 0.
  - Duration is exactly PATCH_VECTOR_SIZE cycles.
  - in_valid and in_vector are ignored; changes after capture do not affect the output.
- DONE:
  - out_valid=1 (registered, equals state==DONE); patch_out holds stable.
  - On an edge with out_taken=1: go to IDLE, clear patch_out to zero, out_valid=0 next cycle.
  - out_taken=0: hold indefinitely.
- Latency: out_valid rises PATCH_VECTOR_SIZE+1 edges after the capture edge (default 17).
- Throughput: at least 1 IDLE cycle between patches. Per-patch period is PATCH_VECTOR_SIZE+2 cycles with immediate out_taken and in_valid held high.
- out_taken outside DONE is ignored. in_valid arriving in the same cycle that DONE exits is not captured; it is captured at the next IDLE edge.
- While not yet written, patch_out holds partial contents and is meaningful only when out_valid=1. Elements not yet written read as zero.
- Index counter width: $clog2(PATCH_VECTOR_SIZE). Row/column derived by division/modulo by PATCH_SIZE; for a power-of-two PATCH_SIZE these are bit slices.
- Reset mid-operation (any state) returns everything to reset values. No partial patch is emitted and in_taken is not re-asserted.

Test Plan:
- Basic ordering:
  - Stimulus: in_vector[k]=k+1 (k=0..15), in_valid=1 for one edge.
  - Required: in_taken pulses 1 cycle; out_valid rises 17 edges after capture.
  - Required: patch_out[r][c]=4r+c+1, e.g. [0][0]=1, [1][2]=7, [3][3]=16; out_taken=1 gives IDLE and patch_out all zero next cycle.
- Backpressure:
  - Stimulus: out_taken held 0 for 10 cycles after out_valid.
  - Required: state stays 2'b10, patch_out unchanged every cycle; release gives IDLE after 1 edge.
- Input isolation:
  - Stimulus: in_vector changed to all 24'hFFFFFF and in_valid kept 1 during PROCESSING.
  - Required: output still equals the originally captured vector; no second in_taken until back in IDLE.
- Mid-operation reset:
  - Stimulus: assert reset after index 7 is written.
  - Required: immediately state=00, out_valid=0, in_taken=0, patch_out zero; a fresh vector afterwards completes correctly.
- Back-to-back:
  - Stimulus: two vectors (base 0x100, base 0x200), in_valid held high, out_taken tied 1.
  - Required: two out_valid pulses 18 cycles apart with correct contents, two in_taken pulses.
- Pixel width:
  - Stimulus: in_vector[5]=24'hABCDEF.
  - Required: patch_out[1][1]=24'hABCDEF, full 24 bits preserved, no channel reordering.
